// File: rtl/status_reg_6502_if.sv
// Bus between the decoder/ALU side and the 6502 status register block.
// The master drives decode controls, ALU flags and interrupt pins; the slave
// (status_reg_6502) returns the P views, ALU feedback flags and interrupt requests.
interface status_reg_6502_if;
  logic       RDY;
  logic       CO;
  logic       V;
  logic       Z;
  logic       N;
  logic       upd_c;
  logic       upd_nz;
  logic       upd_v;
  logic       bit_op;
  logic       plp;
  logic [1:0] flag_op;
  logic [1:0] flag_sel;
  logic [7:0] DI;
  logic       sync;
  logic [1:0] int_ack;
  logic       irq_n;
  logic       nmi_n;
  logic [7:0] P;
  logic [7:0] P_push;
  logic       D;
  logic       C_out;
  logic       irq_req;
  logic       nmi_req;

  modport master (
    output RDY, CO, V, Z, N, upd_c, upd_nz, upd_v, bit_op, plp,
           flag_op, flag_sel, DI, sync, int_ack, irq_n, nmi_n,
    input  P, P_push, D, C_out, irq_req, nmi_req
  );

  modport slave (
    input  RDY, CO, V, Z, N, upd_c, upd_nz, upd_v, bit_op, plp,
           flag_op, flag_sel, DI, sync, int_ack, irq_n, nmi_n,
    output P, P_push, D, C_out, irq_req, nmi_req
  );
endinterface

// File: rtl/status_reg_6502.sv
// 6502 processor status register with IRQ masking and NMI edge capture.
// Optional build macro CMOS_DCLR_EN: interrupt entry (any int_ack) also clears D
// as on the 65C02; without it D is left alone as on the NMOS part.
module status_reg_6502 #(
  parameter bit          I_RESET  = 1'b1,
  parameter int unsigned NMI_SYNC = 2
) (
  input logic            clk,
  input logic            rst_n,
  status_reg_6502_if.slave bus
);

  typedef enum logic [1:0] {
    FOP_NONE = 2'b00,
    FOP_CLR  = 2'b01,
    FOP_SET  = 2'b10,
    FOP_RSV  = 2'b11
  } flag_op_e;

  typedef enum logic [1:0] {
    SEL_C = 2'b00,
    SEL_I = 2'b01,
    SEL_D = 2'b10,
    SEL_V = 2'b11
  } flag_sel_e;

  typedef enum logic [1:0] {
    ACK_NONE = 2'b00,
    ACK_IRQ  = 2'b01,
    ACK_NMI  = 2'b10,
    ACK_BRK  = 2'b11
  } int_ack_e;

  flag_op_e  fop;
  flag_sel_e fsel;
  int_ack_e  ack;

  logic flag_c, flag_z, flag_i, flag_d, flag_v, flag_n, i_mask;
  logic c_nx, z_nx, i_nx, d_nx, v_nx, n_nx, i_mask_nx;

  logic [NMI_SYNC-1:0] nmi_sync, irq_sync;
  logic [NMI_SYNC:0]   nmi_ext, irq_ext;
  logic nmi_prev, nmi_pend, irq_req_q;
  logic nmi_s, irq_s, nmi_edge, nmi_pend_nx;

  logic fop_wr_c, fop_wr_i, fop_wr_d, fop_wr_v, fop_val;
  logic ack_any;

  assign fop  = flag_op_e'(bus.flag_op);
  assign fsel = flag_sel_e'(bus.flag_sel);
  assign ack  = int_ack_e'(bus.int_ack);

  assign ack_any = (ack != ACK_NONE);
  assign fop_val = (fop == FOP_SET);

  assign nmi_ext  = {nmi_sync, bus.nmi_n};
  assign irq_ext  = {irq_sync, bus.irq_n};
  assign nmi_s    = nmi_sync[NMI_SYNC-1];
  assign irq_s    = irq_sync[NMI_SYNC-1];
  assign nmi_edge = nmi_prev & ~nmi_s;

  // Decode which flag the SEx/CLx operation targets; V accepts clear only.
  always_comb begin
    fop_wr_c = 1'b0;
    fop_wr_i = 1'b0;
    fop_wr_d = 1'b0;
    fop_wr_v = 1'b0;
    if (fop == FOP_CLR || fop == FOP_SET) begin
      case (fsel)
        SEL_C:   fop_wr_c = 1'b1;
        SEL_I:   fop_wr_i = 1'b1;
        SEL_D:   fop_wr_d = 1'b1;
        SEL_V:   fop_wr_v = (fop == FOP_CLR);
        default: ;
      endcase
    end
  end

  // Per-bit next-state: plp > int_ack > flag_op > bit_op > upd_*, all gated by RDY.
  always_comb begin
    c_nx      = flag_c;
    z_nx      = flag_z;
    i_nx      = flag_i;
    d_nx      = flag_d;
    v_nx      = flag_v;
    n_nx      = flag_n;
    i_mask_nx = i_mask;
    if (bus.RDY) begin
      if (bus.plp)         c_nx = bus.DI[0];
      else if (fop_wr_c)   c_nx = fop_val;
      else if (bus.upd_c)  c_nx = bus.CO;

      if (bus.plp)         z_nx = bus.DI[1];
      else if (bus.bit_op) z_nx = bus.Z;
      else if (bus.upd_nz) z_nx = bus.Z;

      if (bus.plp)         i_nx = bus.DI[2];
      else if (ack_any)    i_nx = 1'b1;
      else if (fop_wr_i)   i_nx = fop_val;

      if (bus.plp)         d_nx = bus.DI[3];
`ifdef CMOS_DCLR_EN
      else if (ack_any)    d_nx = 1'b0;
`endif
      else if (fop_wr_d)   d_nx = fop_val;

      if (bus.plp)         v_nx = bus.DI[6];
      else if (fop_wr_v)   v_nx = 1'b0;
      else if (bus.bit_op) v_nx = bus.DI[6];
      else if (bus.upd_v)  v_nx = bus.V;

      if (bus.plp)         n_nx = bus.DI[7];
      else if (bus.bit_op) n_nx = bus.DI[7];
      else if (bus.upd_nz) n_nx = bus.N;

      // Mask samples the pre-update I, so CLI/SEI/PLP reach IRQ one instruction late.
      if (ack_any)         i_mask_nx = 1'b1;
      else if (bus.sync)   i_mask_nx = flag_i;
    end
  end

  // NMI pending: a fresh synchronised edge beats a simultaneous acknowledge.
  always_comb begin
    nmi_pend_nx = nmi_pend | nmi_edge;
    if (bus.RDY && ack == ACK_NMI) nmi_pend_nx = nmi_edge;
  end

  // Flag, mask and interrupt state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_i    <= I_RESET;
      flag_d    <= 1'b0;
      flag_v    <= 1'b0;
      flag_n    <= 1'b0;
      i_mask    <= I_RESET;
      nmi_sync  <= '1;
      irq_sync  <= '1;
      nmi_prev  <= 1'b1;
      nmi_pend  <= 1'b0;
      irq_req_q <= 1'b0;
    end else begin
      flag_c    <= c_nx;
      flag_z    <= z_nx;
      flag_i    <= i_nx;
      flag_d    <= d_nx;
      flag_v    <= v_nx;
      flag_n    <= n_nx;
      i_mask    <= i_mask_nx;
      nmi_sync  <= nmi_ext[NMI_SYNC-1:0];
      irq_sync  <= irq_ext[NMI_SYNC-1:0];
      nmi_prev  <= nmi_s;
      nmi_pend  <= nmi_pend_nx;
      irq_req_q <= ~irq_s & ~i_mask;
    end
  end

  assign bus.P       = {flag_n, flag_v, 2'b11, flag_d, flag_i, flag_z, flag_c};
  assign bus.P_push  = {flag_n, flag_v, 1'b1, (ack == ACK_NONE || ack == ACK_BRK),
                        flag_d, flag_i, flag_z, flag_c};
  assign bus.D       = flag_d;
  assign bus.C_out   = flag_c;
  assign bus.irq_req = irq_req_q;
  assign bus.nmi_req = nmi_pend;

endmodule

// File: tb/tb_status_reg_6502.sv
// Directed and randomized check of status_reg_6502 against a flag-level model.
module tb_status_reg_6502;
  localparam int unsigned SYNC = 2;
`ifdef CMOS_DCLR_EN
  localparam bit DCLR = 1'b1;
`else
  localparam bit DCLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  status_reg_6502_if bus ();

  status_reg_6502 #(.I_RESET(1'b1), .NMI_SYNC(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [7:0] mp;
  bit       mmask, mpend, mirq;
  bit       nq[$];
  bit       iq[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic idle();
    bus.RDY = 1'b1; bus.CO = 1'b0; bus.V = 1'b0; bus.Z = 1'b0; bus.N = 1'b0;
    bus.upd_c = 1'b0; bus.upd_nz = 1'b0; bus.upd_v = 1'b0; bus.bit_op = 1'b0;
    bus.plp = 1'b0; bus.flag_op = 2'b00; bus.flag_sel = 2'b00; bus.DI = 8'h00;
    bus.sync = 1'b0; bus.int_ack = 2'b00;
  endtask

  // Advance one clock: model predicts from the applied inputs, then all outputs are compared.
  task automatic step();
    bit [7:0] np;
    bit       nmask, npend, nirq, edge_seen;
    int       pos;
    np = mp; nmask = mmask; npend = mpend; nirq = mirq;
    if (!rst_n) begin
      np = 8'h34; nmask = 1'b1; npend = 1'b0; nirq = 1'b0;
      nq.delete(); iq.delete();
      for (int i = 0; i <= SYNC; i++) nq.push_back(1'b1);
      for (int i = 0; i < SYNC; i++) iq.push_back(1'b1);
    end else begin
      if (bus.RDY) begin
        // Apply writers lowest priority first so higher ones overwrite.
        if (bus.upd_c)  np[0] = bus.CO;
        if (bus.upd_nz) begin np[7] = bus.N; np[1] = bus.Z; end
        if (bus.upd_v)  np[6] = bus.V;
        if (bus.bit_op) begin np[7] = bus.DI[7]; np[6] = bus.DI[6]; np[1] = bus.Z; end
        if (bus.flag_op == 2'b01 || bus.flag_op == 2'b10) begin
          case (bus.flag_sel)
            2'b00: pos = 0;
            2'b01: pos = 2;
            2'b10: pos = 3;
            default: pos = 6;
          endcase
          if (!(pos == 6 && bus.flag_op == 2'b10)) np[pos] = (bus.flag_op == 2'b10);
        end
        if (bus.int_ack != 2'b00) begin
          np[2] = 1'b1;
          if (DCLR) np[3] = 1'b0;
        end
        if (bus.plp) np = bus.DI | 8'h30;
        if (bus.int_ack != 2'b00) nmask = 1'b1;
        else if (bus.sync) nmask = mp[2];
      end
      // nq[0] is the sample SYNC+1 clocks old, nq[1] the current synchronised level.
      edge_seen = nq[0] & ~nq[1];
      if (bus.RDY && bus.int_ack == 2'b10) npend = edge_seen;
      else npend = mpend | edge_seen;
      nirq = ~iq[0] & ~mmask;
      nq.push_back(bus.nmi_n); void'(nq.pop_front());
      iq.push_back(bus.irq_n); void'(iq.pop_front());
    end
    @(posedge clk);
    mp = np; mmask = nmask; mpend = npend; mirq = nirq;
    #1;
    check("P", bus.P, mp);
    check("D", bus.D, mp[3]);
    check("C_out", bus.C_out, mp[0]);
    check("irq_req", bus.irq_req, mirq);
    check("nmi_req", bus.nmi_req, mpend);
    check("P_push", bus.P_push,
          {mp[7:6], 1'b1, (bus.int_ack == 2'b00 || bus.int_ack == 2'b11), mp[3:0]});
  endtask

  initial begin
    idle();
    bus.irq_n = 1'b1; bus.nmi_n = 1'b1;
    rst_n = 1'b0;
    #1;
    step();
    check("reset_P", bus.P, 8'h34);
    check("reset_irq", bus.irq_req, 1'b0);
    check("reset_nmi", bus.nmi_req, 1'b0);
    rst_n = 1'b1;

    // ALU capture of C, N, Z, V
    bus.CO = 1'b1; bus.N = 1'b1; bus.Z = 1'b0; bus.V = 1'b1;
    bus.upd_c = 1'b1; bus.upd_nz = 1'b1; bus.upd_v = 1'b1;
    step();
    check("alu_capture", bus.P, 8'hF5);
    idle();

    // PLP outranks CLC and upd_c on the same bit
    bus.plp = 1'b1; bus.DI = 8'hFF; bus.flag_op = 2'b01; bus.flag_sel = 2'b00;
    bus.upd_c = 1'b1; bus.CO = 1'b0;
    step();
    check("plp_priority", bus.P, 8'hFF);
    idle();

    // CLI latency with IRQ held low and I=1
    bus.irq_n = 1'b0;
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("irq_masked", bus.irq_req, 1'b0);
    bus.sync = 1'b1; bus.flag_op = 2'b01; bus.flag_sel = 2'b01;
    step();
    check("cli_same_sync", bus.irq_req, 1'b0);
    idle();
    step();
    check("cli_before_sync", bus.irq_req, 1'b0);
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    check("cli_sync_edge", bus.irq_req, 1'b0);
    step();
    check("cli_irq_live", bus.irq_req, 1'b1);
    bus.flag_op = 2'b10; bus.flag_sel = 2'b01; bus.sync = 1'b1;
    step();
    idle();
    bus.sync = 1'b1; step(); idle();
    bus.irq_n = 1'b1;
    step();

    // NMI falling edge held low: exactly one request after SYNC+1 clocks
    bus.nmi_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("nmi_edge", bus.nmi_req, (i >= int'(SYNC) + 1) ? 1'b1 : 1'b0);
    end
    bus.int_ack = 2'b10; step(); idle();
    check("nmi_ack", bus.nmi_req, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("nmi_no_reassert", bus.nmi_req, 1'b0);

    // New edge landing on the acknowledge cycle keeps the request
    bus.nmi_n = 1'b1; for (int i = 0; i < 4; i++) step();
    bus.nmi_n = 1'b0; for (int i = 0; i < 3; i++) step();
    bus.nmi_n = 1'b1; for (int i = 0; i < 4; i++) step();
    bus.nmi_n = 1'b0; step(); step();
    bus.int_ack = 2'b10; step(); idle();
    check("nmi_edge_wins", bus.nmi_req, 1'b1);
    bus.int_ack = 2'b10; step(); idle();
    check("nmi_ack2", bus.nmi_req, 1'b0);

    // Decimal flag on interrupt entry
    bus.flag_op = 2'b10; bus.flag_sel = 2'b10; step(); idle();
    check("sed", bus.D, 1'b1);
    bus.int_ack = 2'b01; #1;
    check("push_b_irq", bus.P_push[4], 1'b0);
    step(); idle();
    check("irq_entry_D", bus.D, DCLR ? 1'b0 : 1'b1);
    check("irq_entry_I", bus.P[2], 1'b1);
    bus.int_ack = 2'b11; #1;
    check("push_b_brk", bus.P_push[4], 1'b1);
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      bus.RDY      = ($urandom_range(0, 7) != 0);
      bus.CO       = 1'($urandom);
      bus.V        = 1'($urandom);
      bus.Z        = 1'($urandom);
      bus.N        = 1'($urandom);
      bus.upd_c    = 1'($urandom);
      bus.upd_nz   = 1'($urandom);
      bus.upd_v    = 1'($urandom);
      bus.bit_op   = ($urandom_range(0, 3) == 0);
      bus.plp      = ($urandom_range(0, 7) == 0);
      bus.flag_op  = 2'($urandom);
      bus.flag_sel = 2'($urandom);
      bus.DI       = 8'($urandom);
      bus.sync     = ($urandom_range(0, 2) == 0);
      bus.int_ack  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 7) == 0) bus.irq_n = ~bus.irq_n;
      if ($urandom_range(0, 5) == 0) bus.nmi_n = ~bus.nmi_n;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
